out_fifo_index_arbiter: RTL and testbench

//  Shares the single out-FIFO write port among N_REQ byte producers (varint encoder, raw-data path, header gen).

---
 rtl/out_fifo_index_arbiter.sv | 175 +++++++++++++++++
 tb/tb_out_fifo_index_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fifo_index_arbiter.sv
// Shares one out-FIFO write port among N_REQ byte producers and writes bytes strictly in
// message-position order. Missing positions (stall timeout) and duplicate owners are flagged.
module out_fifo_index_arbiter #(
    parameter int N_REQ   = 3,
    parameter int IDX_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [IDX_W-1:0]       msg_len,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IDX_W-1:0] req_index,
    input  logic [N_REQ*8-1:0]     req_data,
    output logic [N_REQ-1:0]       req_pop,
    input  logic                   out_fifo_full,
    output logic                   out_fifo_push,
    output logic [7:0]             out_fifo_data,
    output logic                   out_fifo_clr,
    output logic                   busy,
    output logic                   done,
    output logic                   err_timeout,
    output logic                   err_dup
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0]       STALL_LAST = 8'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [7:0]       stall_q, stall_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_dup_q, err_dup_d;

    logic [N_REQ-1:0] match;
    logic [N_REQ-1:0] win_oh;
    logic [7:0]       win_data;
    logic             win_found;
    logic             multi_match;

    logic [N_REQ-1:0] pop_c;
    logic             push_c;
    logic [7:0]       data_c;
    logic             clr_c;
    logic             done_c;

    // A producer owns the current slot only when its tag equals out_index on all IDX_W bits.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_match
            assign match[gi] = req_valid[gi] &&
                               (req_index[gi*IDX_W +: IDX_W] == out_index_q);
        end
    endgenerate

    assign multi_match = ($countones(match) > 1);

    // Lowest-numbered matching producer wins.
    always_comb begin
        win_oh    = '0;
        win_data  = 8'h00;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (match[i] && !win_found) begin
                win_found = 1'b1;
                win_oh[i] = 1'b1;
                win_data  = req_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        out_index_d   = out_index_q;
        len_d         = len_q;
        stall_d       = stall_q;
        err_timeout_d = err_timeout_q;
        err_dup_d     = err_dup_q;
        pop_c         = '0;
        push_c        = 1'b0;
        data_c        = 8'h00;
        clr_c         = 1'b0;
        done_c        = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            clr_c   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        len_d         = msg_len;
                        err_timeout_d = 1'b0;
                        err_dup_d     = 1'b0;
                        state_d       = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_c       = 1'b1;
                    out_index_d = '0;
                    stall_d     = 8'h00;
                    state_d     = (len_q != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (multi_match) begin
                        err_dup_d = 1'b1;
                    end
                    if (win_found) begin
                        // A present owner blocked by a full FIFO is backpressure, not a stall.
                        stall_d = 8'h00;
                        if (!out_fifo_full) begin
                            push_c      = 1'b1;
                            data_c      = win_data;
                            pop_c       = win_oh;
                            out_index_d = out_index_q + IDX_ONE;
                            if (out_index_q == len_q - IDX_ONE) begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        stall_d = stall_q + 8'h01;
                        if (stall_q == STALL_LAST) begin
                            err_timeout_d = 1'b1;
                            state_d       = S_ERROR;
                        end
                    end
                end
                S_DONE: begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            out_index_q   <= '0;
            len_q         <= '0;
            stall_q       <= 8'h00;
            err_timeout_q <= 1'b0;
            err_dup_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_index_q   <= out_index_d;
            len_q         <= len_d;
            stall_q       <= stall_d;
            err_timeout_q <= err_timeout_d;
            err_dup_q     <= err_dup_d;
        end
    end

    assign req_pop       = pop_c;
    assign out_fifo_push = push_c;
    assign out_fifo_data = data_c;
    assign out_fifo_clr  = clr_c;
    assign done          = done_c;
    assign busy          = (state_q != S_IDLE);
    assign err_timeout   = err_timeout_q;
    assign err_dup       = err_dup_q;

endmodule

// File: tb/tb_out_fifo_index_arbiter.sv
// Directed bench for out_fifo_index_arbiter: a message-level model predicts every output each
// cycle, and literal expectations pin push counts, byte order, timing and flag behaviour.
module tb_out_fifo_index_arbiter;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DONE  = 3;
    localparam int PH_ERR   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [9:0]  msg_len;
    logic [2:0]  req_valid;
    logic [29:0] req_index;
    logic [23:0] req_data;
    logic [2:0]  req_pop;
    logic        out_fifo_full;
    logic        out_fifo_push;
    logic [7:0]  out_fifo_data;
    logic        out_fifo_clr;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_dup;

    always #5 clk = ~clk;

    out_fifo_index_arbiter #(.N_REQ(3), .IDX_W(10), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .msg_len(msg_len),
        .req_valid(req_valid), .req_index(req_index), .req_data(req_data),
        .req_pop(req_pop), .out_fifo_full(out_fifo_full), .out_fifo_push(out_fifo_push),
        .out_fifo_data(out_fifo_data), .out_fifo_clr(out_fifo_clr), .busy(busy),
        .done(done), .err_timeout(err_timeout), .err_dup(err_dup)
    );

    // Producer queues (stimulus side)
    logic [9:0] p_idx [0:2][0:1023];
    logic [7:0] p_dat [0:2][0:1023];
    int         p_len [0:2];
    int         p_head[0:2];

    // Compare-process state
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         m_ph = PH_IDLE, m_pos = 0, m_len = 0, m_stall = 0;
    int         n_ph, n_pos, n_len, n_stall;
    logic       m_dup = 1'b0, m_to = 1'b0, n_dup, n_to;
    logic       e_push, e_clr, e_busy, e_done, e_dup, e_to;
    logic [2:0] e_pop;
    logic [7:0] e_data;
    logic [2:0] own;
    int         win;
    logic [2:0] pend_pop = 3'b000;
    int         push_cnt = 0, done_cnt = 0, clr_cnt = 0, pop2_cnt = 0, done_cyc = 0;
    logic [7:0] push_log [0:2047];
    int         push_cyc [0:2047];

    // Literal check request from stimulus, evaluated by the compare process
    logic       lit_valid = 1'b0;
    string      lit_name = "";
    int         lit_act = 0, lit_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            m_ph = PH_IDLE; m_pos = 0; m_len = 0; m_stall = 0; m_dup = 1'b0; m_to = 1'b0;
        end
        e_push = 1'b0; e_pop = 3'b000; e_data = 8'h00; e_clr = 1'b0; e_done = 1'b0;
        e_busy = (m_ph != PH_IDLE);
        e_dup  = m_dup;
        e_to   = m_to;
        n_ph = m_ph; n_pos = m_pos; n_len = m_len; n_stall = m_stall; n_dup = m_dup; n_to = m_to;
        if (reset) begin
            own = 3'b000;
            win = -1;
            for (int p = 0; p < 3; p++) begin
                own[p] = req_valid[p] && (int'(req_index[p*10 +: 10]) == m_pos);
                if (own[p] && win < 0) win = p;
            end
            if (abort) begin
                e_clr = 1'b1;
                n_ph  = PH_IDLE;
            end else begin
                case (m_ph)
                    PH_IDLE, PH_ERR: if (start) begin
                        n_len = int'(msg_len); n_dup = 1'b0; n_to = 1'b0; n_ph = PH_CLEAR;
                    end
                    PH_CLEAR: begin
                        e_clr = 1'b1; n_pos = 0; n_stall = 0;
                        n_ph = (m_len == 0) ? PH_DONE : PH_RUN;
                    end
                    PH_RUN: begin
                        if ($countones(own) > 1) n_dup = 1'b1;
                        if (win < 0) begin
                            n_stall = m_stall + 1;
                            if (n_stall == 255) begin n_to = 1'b1; n_ph = PH_ERR; end
                        end else begin
                            n_stall = 0;
                            if (!out_fifo_full) begin
                                e_push = 1'b1;
                                e_data = req_data[win*8 +: 8];
                                e_pop[win] = 1'b1;
                                n_pos = m_pos + 1;
                                if (n_pos == m_len) n_ph = PH_DONE;
                            end
                        end
                    end
                    PH_DONE: begin e_done = 1'b1; n_ph = PH_IDLE; end
                    default: ;
                endcase
            end
        end
        chk("push", int'(out_fifo_push), int'(e_push));
        chk("pop", int'(req_pop), int'(e_pop));
        if (e_push) chk("data", int'(out_fifo_data), int'(e_data));
        chk("clr", int'(out_fifo_clr), int'(e_clr));
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(e_done));
        chk("err_timeout", int'(err_timeout), int'(e_to));
        chk("err_dup", int'(err_dup), int'(e_dup));

        if (out_fifo_push && push_cnt < 2048) begin
            push_log[push_cnt] = out_fifo_data;
            push_cyc[push_cnt] = cyc;
            $display("push %0d data 0x%02h cycle %0d", push_cnt, out_fifo_data, cyc);
            push_cnt++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (out_fifo_clr) clr_cnt++;
        if (req_pop[2]) pop2_cnt++;
        pend_pop = e_pop;
        if (lit_valid) chk(lit_name, lit_act, lit_exp);

        m_ph = n_ph; m_pos = n_pos; m_len = n_len; m_stall = n_stall; m_dup = n_dup; m_to = n_to;
    end

    // ---------------- stimulus ----------------
    task automatic drive_prod();
        for (int p = 0; p < 3; p++) begin
            if (p_head[p] < p_len[p]) begin
                req_valid[p]         = 1'b1;
                req_index[p*10 +: 10] = p_idx[p][p_head[p]];
                req_data[p*8 +: 8]    = p_dat[p][p_head[p]];
            end else begin
                req_valid[p]         = 1'b0;
                req_index[p*10 +: 10] = 10'd0;
                req_data[p*8 +: 8]    = 8'h00;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) if (pend_pop[p] && p_head[p] < p_len[p]) p_head[p]++;
        drive_prod();
    endtask

    task automatic clear_prod();
        for (int p = 0; p < 3; p++) begin p_len[p] = 0; p_head[p] = 0; end
        drive_prod();
    endtask

    task automatic add(input int p, input int idx, input int dat);
        logic [31:0] d;
        d = dat;
        p_idx[p][p_len[p]] = 10'(idx);
        p_dat[p][p_len[p]] = d[7:0];
        p_len[p]++;
        drive_prod();
    endtask

    task automatic load_interleave();
        clear_prod();
        add(0, 0, 'hA0); add(0, 2, 'hA2); add(0, 3, 'hA3);
        add(1, 1, 'hA1); add(1, 4, 'hA4); add(1, 5, 'hA5);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        lit_name = name; lit_act = act; lit_exp = exp; lit_valid = 1'b1;
        tick();
        lit_valid = 1'b0;
    endtask

    task automatic start_msg(input int len);
        msg_len = 10'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, b;
        d0 = done_cnt; b = 0;
        while (done_cnt == d0 && b < budget) begin tick(); b++; end
        if (done_cnt == d0) lit("wait_done_expired", 0, 1);
    endtask

    task automatic wait_pushes(input int base, input int n, input int budget);
        int b;
        b = 0;
        while (push_cnt - base < n && b < budget) begin tick(); b++; end
        if (push_cnt - base < n) lit("wait_push_expired", push_cnt - base, n);
    endtask

    initial begin
        int base, c0, p20, b, outs;
        reset = 1'b0; start = 1'b0; abort = 1'b0; msg_len = 10'd0; out_fifo_full = 1'b0;
        req_valid = 3'b000; req_index = '0; req_data = '0;
        clear_prod();
        tick(); tick();
        lit("reset_busy", int'(busy), 0);
        reset = 1'b1;
        tick();

        // T1 interleave
        load_interleave();
        base = push_cnt;
        start_msg(6);
        wait_done(50);
        lit("t1_pushes", push_cnt - base, 6);
        for (int k = 0; k < 6; k++) lit("t1_byte", int'(push_log[base + k]), 'hA0 + k);
        lit("t1_back_to_back", push_cyc[base + 5] - push_cyc[base], 5);
        lit("t1_done_after_last", done_cyc - push_cyc[base + 5], 1);

        // T2 backpressure
        load_interleave();
        base = push_cnt;
        start_msg(6);
        wait_pushes(base, 3, 20);
        out_fifo_full = 1'b1;
        repeat (300) tick();
        lit("t2_held_pushes", push_cnt - base, 3);
        out_fifo_full = 1'b0;
        wait_done(50);
        lit("t2_pushes", push_cnt - base, 6);
        lit("t2_resume_byte", int'(push_log[base + 3]), 'hA3);
        lit("t2_no_timeout", int'(err_timeout), 0);

        // T3 gap at idx 2
        clear_prod();
        add(0, 0, 'hC0); add(0, 1, 'hC1); add(0, 3, 'hC3);
        base = push_cnt;
        start_msg(4);
        b = 0;
        while (!err_timeout && b < 400) begin tick(); b++; end
        lit("t3_err_timeout", int'(err_timeout), 1);
        lit("t3_pushes", push_cnt - base, 2);
        lit("t3_busy_in_error", int'(busy), 1);
        c0 = clr_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        lit("t3_abort_clr", clr_cnt - c0, 1);
        lit("t3_idle", int'(busy), 0);

        // T4 duplicate owners of idx 0
        clear_prod();
        add(0, 0, 'hB0); add(1, 1, 'hB1); add(2, 0, 'hD0);
        base = push_cnt;
        p20 = pop2_cnt;
        start_msg(2);
        wait_done(50);
        lit("t4_pushes", push_cnt - base, 2);
        lit("t4_byte0", int'(push_log[base]), 'hB0);
        lit("t4_byte1", int'(push_log[base + 1]), 'hB1);
        lit("t4_p2_pops", pop2_cnt - p20, 0);
        lit("t4_err_dup", int'(err_dup), 1);

        // T5 zero-length message, then maximum length
        clear_prod();
        base = push_cnt;
        c0 = clr_cnt;
        start_msg(0);
        wait_done(10);
        lit("t5_zero_pushes", push_cnt - base, 0);
        lit("t5_zero_clr", clr_cnt - c0, 1);
        lit("t5_dup_cleared", int'(err_dup), 0);
        clear_prod();
        for (int k = 0; k < 1023; k++) add(0, k, k);
        base = push_cnt;
        start_msg(1023);
        wait_done(1100);
        lit("t5_max_pushes", push_cnt - base, 1023);
        lit("t5_last_byte", int'(push_log[base + 1022]), 'hFE);
        repeat (4) tick();
        lit("t5_no_wrap", push_cnt - base, 1023);

        // T6 abort at idx 3, then restart
        load_interleave();
        base = push_cnt;
        start_msg(6);
        wait_pushes(base, 3, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        lit("t6_abort_idle", int'(busy), 0);
        lit("t6_abort_pushes", push_cnt - base, 3);
        load_interleave();
        base = push_cnt;
        start_msg(6);
        wait_done(50);
        lit("t6_restart_pushes", push_cnt - base, 6);
        lit("t6_restart_byte0", int'(push_log[base]), 'hA0);

        // T6 reset at idx 3
        load_interleave();
        base = push_cnt;
        start_msg(6);
        wait_pushes(base, 3, 20);
        reset = 1'b0;
        #2;
        outs = int'({req_pop, out_fifo_push, out_fifo_data, out_fifo_clr, busy, done,
                     err_timeout, err_dup});
        lit("t6_reset_outputs", outs, 0);
        reset = 1'b1;
        clear_prod();
        repeat (3) tick();
        lit("t6_after_reset_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
